usb_rx_deframer: RTL
====================

USB_RX_DEFRAMER -- requirements
Module: usb_rx_deframer

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 4, meaning clk cycles per full-speed bit time (even, >=4).
REQ-002 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port d_plus  input  1  raw D+ line, asynchronous to clk.
REQ-005 SHALL have port d_minus  input  1  raw D- line, asynchronous to clk.
REQ-006 SHALL have port rx_eop  input  1  end-of-packet level from the SE0 detector stage.
REQ-007 SHALL have port rx_data  output  8  received byte, LSB first on wire.
REQ-008 SHALL have port rx_valid  output  1  rx_data holds an unconsumed byte.
REQ-009 SHALL have port rx_ready  input  1  consumer accepts; transfer when rx_valid && rx_ready.
REQ-010 SHALL have port rx_active  output  1  high from SYNC match until packet end.
REQ-011 SHALL have port rx_error  output  1  one-cycle pulse on stuff, overflow or partial-byte error.

Function
REQ-012 SHALL double-flop d_plus/d_minus before any use; line J = (1,0), K = (0,1), SE0 = (0,0).
REQ-013 SHALL run a phase counter 0..CLKS_PER_BIT-1 (wraps), cleared on any clk where the synchronized line differs from the previous cycle.
REQ-014 SHALL generate a sample strobe when phase == CLKS_PER_BIT/2-1; SE0 samples do not update the decoder.
REQ-015 SHALL NRZI-decode: bit = 1 if sampled J/K equals previous sample, else 0; previous sample resets to J.
REQ-016 SHALL implement states IDLE, SYNC, DATA, ERROR.
REQ-017 IDLE -> SYNC on first K sample; SYNC shift register cleared.
REQ-018 SYNC -> DATA when last 8 decoded bits (LSB first) equal 8'h80, i.e. 0,0,0,0,0,0,0,1; rx_active rises the next cycle.
REQ-019 SYNC -> IDLE after 16 bit samples without match, no rx_error.
REQ-020 SHALL count consecutive decoded 1s in DATA; after six 1s the next bit SHALL be discarded if 0.
REQ-021 Seventh consecutive 1 SHALL pulse rx_error and enter ERROR; no further bytes emitted.
REQ-022 SHALL assemble 8 kept bits LSB first; on 8th bit load rx_data, set rx_valid the next cycle.
REQ-023 rx_valid SHALL stay high and rx_data stable until handshake; clears cycle after rx_valid && rx_ready.
REQ-024 New byte completing while rx_valid && !rx_ready SHALL be dropped, pulse rx_error, enter ERROR.
REQ-025 Byte completing on same cycle as handshake SHALL load without error.
REQ-026 Rising edge of rx_eop in SYNC, DATA or ERROR SHALL force IDLE, drop rx_active next cycle, clear counters.
REQ-027 rx_eop rising edge in DATA with 1..7 bits pending SHALL pulse rx_error; pending bits discarded.
REQ-028 A pending rx_valid byte SHALL survive packet end until accepted.

Reset
REQ-029 rst_n low SHALL asynchronously set state IDLE, rx_data 0, rx_valid 0, rx_active 0, rx_error 0, counters 0, previous sample J.
REQ-030 Reset mid-packet SHALL discard all partial data; first post-reset packet requires full SYNC.

Configuration
REQ-031 Macro USB_RX_STATS_EN defined: ports pkt_count[15:0] and err_count[15:0] (outputs) SHALL exist, incrementing on each DATA->IDLE exit and each rx_error pulse, saturating at 16'hFFFF, reset 0.
REQ-032 Macro undefined: those ports and counters SHALL not exist; all other behaviour identical.

Structure
REQ-033 Package usb_rx_pkg SHALL hold state enum, SYNC_PATTERN (8'h80), MAX_ONES (6), SYNC_TIMEOUT (16), stats width.
REQ-034 Sub-module usb_rx_bit_sampler SHALL contain synchronizers, phase counter and strobe, outputting sample strobe and line state.

Verification
REQ-035 CLKS_PER_BIT=4, SYNC then byte 8'hA5, rx_ready=1, then SE0 -> rx_data=8'hA5, rx_valid one cycle, rx_active falls after rx_eop edge, no rx_error.
REQ-036 Byte 8'hFF after SYNC with stuffed 0 inserted -> rx_data=8'hFF, stuffed bit removed, no error.
REQ-037 Seven consecutive decoded 1s -> rx_error single pulse, state ERROR, no rx_valid until next packet.
REQ-038 Two bytes 8'h12, 8'h34, rx_ready=0 -> rx_data holds 8'h12, second byte dropped, rx_error pulse.
REQ-039 SE0 after 3 data bits -> rx_error pulse, IDLE, rx_valid stays 0.
REQ-040 rst_n low mid-byte, release, send valid packet 8'h3C -> only 8'h3C delivered; with USB_RX_STATS_EN pkt_count=1, err_count=0.

Source files
------------

// File: rtl/usb_rx_pkg.sv
// Shared types and constants for the USB full-speed receive deframer.
package usb_rx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SYNC,
    ST_DATA,
    ST_ERROR
  } state_t;

  localparam logic [7:0]  SYNC_PATTERN = 8'h80;
  localparam int unsigned MAX_ONES     = 6;
  localparam int unsigned SYNC_TIMEOUT = 16;
  localparam int unsigned STATS_W      = 16;

  // Line states as {d_plus, d_minus}
  localparam logic [1:0] LINE_J = 2'b10;
  localparam logic [1:0] LINE_K = 2'b01;

  function automatic logic [STATS_W-1:0] sat_inc(input logic [STATS_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/usb_rx_bit_sampler.sv
// Synchronizes the raw D+/D- pair and produces one mid-bit sample strobe per bit time.
module usb_rx_bit_sampler
  import usb_rx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       d_plus,
  input  logic       d_minus,
  output logic       strobe,
  output logic [1:0] line
);

  localparam int unsigned PW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  logic [1:0]    meta;
  logic [1:0]    sync;
  logic [1:0]    line_prev;
  logic [PW-1:0] phase;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta      <= LINE_J;
      sync      <= LINE_J;
      line_prev <= LINE_J;
      phase     <= '0;
    end else begin
      meta      <= {d_plus, d_minus};
      sync      <= meta;
      line_prev <= sync;
      if (sync != line_prev)
        phase <= '0;
      else if (phase == PW'(CLKS_PER_BIT - 1))
        phase <= '0;
      else
        phase <= phase + 1'b1;
    end
  end

  // The transition cycle itself belongs to phase 0, so never strobe there.
  assign strobe = (phase == PW'(CLKS_PER_BIT / 2 - 1)) && (sync == line_prev);
  assign line   = sync;

endmodule

// File: rtl/usb_rx_deframer.sv
// USB full-speed receive deframer: NRZI decode, SYNC hunt, bit unstuffing, byte handshake.
// Optional statistics counters are enabled by defining USB_RX_STATS_EN.
module usb_rx_deframer
  import usb_rx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               d_plus,
  input  logic               d_minus,
  input  logic               rx_eop,
  output logic [7:0]         rx_data,
  output logic               rx_valid,
  input  logic               rx_ready,
  output logic               rx_active,
  output logic               rx_error
`ifdef USB_RX_STATS_EN
  ,
  output logic [STATS_W-1:0] pkt_count,
  output logic [STATS_W-1:0] err_count
`endif
);

  logic       strobe;
  logic [1:0] line;
  state_t     state;
  logic       prev_j;
  logic [6:0] sync_sr;
  logic [3:0] sync_cnt;
  logic [2:0] ones_cnt;
  logic [2:0] bit_cnt;
  logic [6:0] data_sr;
  logic       eop_d;

  logic       sample;
  logic       is_j;
  logic       dbit;
  logic       eop_rise;
  logic [7:0] sync_next;
  logic [7:0] byte_next;

  usb_rx_bit_sampler #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_sampler (
    .clk    (clk),
    .rst_n  (rst_n),
    .d_plus (d_plus),
    .d_minus(d_minus),
    .strobe (strobe),
    .line   (line)
  );

  assign is_j      = (line == LINE_J);
  assign sample    = strobe && (is_j || (line == LINE_K));
  assign dbit      = (is_j == prev_j);
  assign eop_rise  = rx_eop && !eop_d;
  assign sync_next = {dbit, sync_sr};
  assign byte_next = {dbit, data_sr};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      prev_j    <= 1'b1;
      sync_sr   <= '0;
      sync_cnt  <= '0;
      ones_cnt  <= '0;
      bit_cnt   <= '0;
      data_sr   <= '0;
      eop_d     <= 1'b0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      rx_active <= 1'b0;
      rx_error  <= 1'b0;
    end else begin
      eop_d    <= rx_eop;
      rx_error <= 1'b0;
      if (rx_valid && rx_ready)
        rx_valid <= 1'b0;
      if (sample)
        prev_j <= is_j;

      if (eop_rise && state != ST_IDLE) begin
        state     <= ST_IDLE;
        rx_active <= 1'b0;
        prev_j    <= 1'b1;
        sync_sr   <= '0;
        sync_cnt  <= '0;
        ones_cnt  <= '0;
        bit_cnt   <= '0;
        if (state == ST_DATA && bit_cnt != 3'd0)
          rx_error <= 1'b1;
      end else if (sample) begin
        case (state)
          ST_IDLE: begin
            if (!is_j) begin
              state    <= ST_SYNC;
              sync_sr  <= '0;
              sync_cnt <= '0;
            end
          end
          ST_SYNC: begin
            if (sync_next == SYNC_PATTERN) begin
              state     <= ST_DATA;
              rx_active <= 1'b1;
              ones_cnt  <= '0;
              bit_cnt   <= '0;
            end else if (sync_cnt == 4'(SYNC_TIMEOUT - 1)) begin
              state <= ST_IDLE;
            end else begin
              sync_sr  <= sync_next[7:1];
              sync_cnt <= sync_cnt + 4'd1;
            end
          end
          ST_DATA: begin
            // After MAX_ONES ones the next bit is either a stuffed 0 or a violation.
            if (ones_cnt == 3'(MAX_ONES)) begin
              if (dbit) begin
                rx_error <= 1'b1;
                state    <= ST_ERROR;
              end else begin
                ones_cnt <= '0;
              end
            end else begin
              ones_cnt <= dbit ? ones_cnt + 3'd1 : 3'd0;
              data_sr  <= byte_next[7:1];
              bit_cnt  <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                if (rx_valid && !rx_ready) begin
                  rx_error <= 1'b1;
                  state    <= ST_ERROR;
                end else begin
                  rx_data  <= byte_next;
                  rx_valid <= 1'b1;
                end
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

`ifdef USB_RX_STATS_EN
  logic pkt_exit;
  assign pkt_exit = eop_rise && (state == ST_DATA);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_count <= '0;
      err_count <= '0;
    end else begin
      if (pkt_exit)
        pkt_count <= sat_inc(pkt_count);
      if (rx_error)
        err_count <= sat_inc(err_count);
    end
  end
`endif

endmodule
